// File: rtl/mem_image_loader.sv
// Boot loader: assembles a little-endian byte stream into words, writes the payload to
// the byte-banked memories, verifies the XOR trailer, and then releases the CPU from reset.
module mem_image_loader #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_di,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    HDR_ADDR = 3'd0,
    HDR_CNT  = 3'd1,
    PAYLOAD  = 3'd2,
    CHECK    = 3'd3,
    DONE     = 3'd4,
    ERROR    = 3'd5
  } state_t;

  localparam int SUM_W = ADDR_W + 33;
  localparam logic [SUM_W-1:0] DEPTH = SUM_W'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [31:0]         word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         remaining_q, remaining_d;
  logic [31:0]         csum_q, csum_d;
  logic [3:0]          mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_di_q, mem_di_d;

  logic                accept;
  logic                word_done;
  logic [31:0]         word_full;
  logic [SUM_W-1:0]    range_end;

  assign in_ready  = !rst && (state_q == HDR_ADDR || state_q == HDR_CNT ||
                              state_q == PAYLOAD  || state_q == CHECK);
  assign accept    = in_valid && in_ready;
  assign word_done = accept && (byte_cnt_q == 2'd3);
  // The fourth byte is used straight off the bus so a completed word acts in its own cycle.
  assign word_full = {in_data, word_q[23:0]};
  assign range_end = SUM_W'(addr_q) + SUM_W'(word_full);

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_di   = mem_di_q;
  assign done     = (state_q == DONE);
  assign err      = (state_q == ERROR);
  assign cpu_rst  = (state_q != DONE);

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    csum_d      = csum_q;
    mem_we_d    = 4'h0;
    mem_addr_d  = mem_addr_q;
    mem_di_d    = mem_di_q;

    if (accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    word_d[7:0]   = in_data;
        2'd1:    word_d[15:8]  = in_data;
        2'd2:    word_d[23:16] = in_data;
        default: word_d[31:24] = in_data;
      endcase
    end

    if (word_done) begin
      case (state_q)
        HDR_ADDR: begin
          addr_d  = word_full[ADDR_W-1:0];
          state_d = HDR_CNT;
        end
        HDR_CNT: begin
          remaining_d = word_full;
          if (range_end > DEPTH)        state_d = ERROR;
          else if (word_full == 32'd0)  state_d = CHECK;
          else                          state_d = PAYLOAD;
        end
        PAYLOAD: begin
          mem_we_d    = 4'hF;
          mem_addr_d  = addr_q;
          mem_di_d    = word_full;
          csum_d      = csum_q ^ word_full;
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - 32'd1;
          if (remaining_q == 32'd1) state_d = CHECK;
        end
        CHECK: begin
          state_d = (word_full == csum_q) ? DONE : ERROR;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HDR_ADDR;
      byte_cnt_q  <= 2'd0;
      word_q      <= 32'd0;
      addr_q      <= '0;
      remaining_q <= 32'd0;
      csum_q      <= 32'd0;
      mem_we_q    <= 4'h0;
      mem_addr_q  <= '0;
      mem_di_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      csum_q      <= csum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_di_q    <= mem_di_d;
    end
  end

endmodule

// File: tb/tb_mem_image_loader.sv
// Directed bench for mem_image_loader: a table of image loads plus a mid-load reset sequence.
module tb_mem_image_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_di;
  logic        cpu_rst, done, err;

  mem_image_loader #(.ADDR_W(14)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] start;
    logic [31:0] n;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [31:0] trailer;
    int          gap;
    bit          hdr_only;
    bit          exp_done;
    int          exp_writes;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [13:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [3:0]  wr_we[$];

  always @(negedge clk) begin
    if (!rst && mem_we != 4'h0) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_di);
      wr_we.push_back(mem_we);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 32'(rst ? 1'b0 : 1'b1));
    chk({tag, " mem_we"},   32'(mem_we),   32'h0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, " mem_di"},   mem_di,        32'h0);
    chk({tag, " cpu_rst"},  32'(cpu_rst),  32'h1);
    chk({tag, " done"},     32'(done),     32'h0);
    chk({tag, " err"},      32'(err),      32'h0);
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    budget   = 50;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready timeout: got 0, want 1");
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input bit first);
    for (int k = 0; k < 4; k++)
      send_byte(w[8*k +: 8], (first && k == 0) ? 0 : gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wr_addr.delete();
    wr_data.delete();
    wr_we.delete();
  endtask

  task automatic apply(input vec_t v, input bit with_reset);
    logic [31:0] pay[2];
    pay[0] = v.p0;
    pay[1] = v.p1;
    if (with_reset) begin
      do_reset();
      chk_reset_outputs({v.name, " post-reset"});
    end
    send_word(v.start, v.gap, 1'b1);
    send_word(v.n, v.gap, 1'b0);
    if (!v.hdr_only) begin
      for (int i = 0; i < int'(v.n); i++) send_word(pay[i], v.gap, 1'b0);
      send_word(v.trailer, v.gap, 1'b0);
    end
    chk({v.name, " done"},     32'(done),     32'(v.exp_done));
    chk({v.name, " err"},      32'(err),      32'(!v.exp_done));
    chk({v.name, " cpu_rst"},  32'(cpu_rst),  32'(!v.exp_done));
    chk({v.name, " in_ready"}, 32'(in_ready), 32'h0);
    repeat (3) @(negedge clk);
    chk({v.name, " sticky done"}, 32'(done), 32'(v.exp_done));
    chk({v.name, " sticky err"},  32'(err),  32'(!v.exp_done));
    chk({v.name, " write count"}, 32'(wr_addr.size()), 32'(v.exp_writes));
    for (int i = 0; i < v.exp_writes && i < wr_addr.size(); i++) begin
      chk($sformatf("%s wr%0d we", v.name, i),   32'(wr_we[i]),   32'hF);
      chk($sformatf("%s wr%0d addr", v.name, i), 32'(wr_addr[i]), v.start[13:0] + 32'(i));
      chk($sformatf("%s wr%0d data", v.name, i), wr_data[i],      pay[i]);
    end
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"basic",    32'h0,    32'd2, 32'h00000013, 32'hFFFFFFFF, 32'hFFFFFFEC, 0, 1'b0, 1'b1, 2};
    vecs[1] = '{"gaps",     32'h2000, 32'd1, 32'h44332211, 32'h0,        32'h44332211, 3, 1'b0, 1'b1, 1};
    vecs[2] = '{"csumfail", 32'h0,    32'd2, 32'h00000013, 32'hFFFFFFFF, 32'h00000000, 0, 1'b0, 1'b0, 2};
    vecs[3] = '{"top1",     32'h3fff, 32'd1, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1, 1'b0, 1'b1, 1};
    vecs[4] = '{"top2",     32'h3fff, 32'd2, 32'h0,        32'h0,        32'h0,        0, 1'b1, 1'b0, 0};
    vecs[5] = '{"n0ok",     32'h0123, 32'd0, 32'h0,        32'h0,        32'h00000000, 0, 1'b0, 1'b1, 0};
    vecs[6] = '{"n0bad",    32'h0123, 32'd0, 32'h0,        32'h0,        32'h00000001, 2, 1'b0, 1'b0, 0};

    // Reset state while rst is still high.
    repeat (2) @(negedge clk);
    chk_reset_outputs("in-reset");

    foreach (vecs[i]) apply(vecs[i], 1'b1);

    // Reset two bytes into the first payload word of a basic load, then a clean reload.
    do_reset();
    send_word(32'h0, 0, 1'b1);
    send_word(32'd2, 0, 1'b0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midload-rst");
    rst = 1'b0;
    @(negedge clk);
    chk("midload-rst no writes", 32'(wr_addr.size()), 32'h0);
    chk("midload-rst in_ready", 32'(in_ready), 32'h1);
    apply(vecs[0], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
